// File: rtl/cfg_desc_pkg.sv
// Shared constants, state type and saturation helpers for the descriptor streamer.
// Optional feature macro: CFG_DESC_CHECKSUM_EN (appends an XOR checksum word).
package cfg_desc_pkg;

    localparam logic [15:0] DESC_MAGIC  = 16'hC7A6;
    localparam int unsigned NWORDS_BASE = 8;
`ifdef CFG_DESC_CHECKSUM_EN
    localparam int unsigned NWORDS      = NWORDS_BASE + 1;
`else
    localparam int unsigned NWORDS      = NWORDS_BASE;
`endif

    localparam int unsigned IDX_W       = 4;
    localparam int unsigned FW_NIBBLE   = 4;
    localparam int unsigned FW_BYTE     = 8;
    localparam int unsigned FW_HALF     = 16;
    localparam int unsigned MAGIC_LSB   = 16;
    localparam int unsigned NFLAGS      = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    // Oversized values clamp to all-ones rather than wrapping.
    function automatic logic [FW_NIBBLE-1:0] sat4(input logic [31:0] v);
        return (v > 32'h0000_000F) ? 4'hF : v[FW_NIBBLE-1:0];
    endfunction

    function automatic logic [FW_BYTE-1:0] sat8(input logic [31:0] v);
        return (v > 32'h0000_00FF) ? 8'hFF : v[FW_BYTE-1:0];
    endfunction

    function automatic logic [FW_HALF-1:0] sat16(input logic [31:0] v);
        return (v > 32'h0000_FFFF) ? 16'hFFFF : v[FW_HALF-1:0];
    endfunction

endpackage

// File: rtl/config_pkg.sv
// Core configuration record: the subset of the CVA6 elaborated configuration
// that cfg_desc_streamer serializes. Every numeric field is 32 bits wide so oversized values can be saturated.
package config_pkg;

    typedef struct packed {
        logic [31:0] XLEN, VLEN, PLEN, GPLEN;
        logic        RVF, RVD, XF16, XF16ALT, XF8, RVA, RVB, RVV, RVC, RVH, RVZCB;
        logic        RVZCMP, XFVec, CvxifEn, RVZiCond, RVZicntr, RVZihpm, RVS, RVU;
        logic        MmuPresent, DebugEn, FpPresent;
        logic [31:0] FLen, NR_SB_ENTRIES, NrRgprPorts, NrWbPorts, NrIssuePorts, NrCommitPorts;
        logic [31:0] DCACHE_INDEX_WIDTH, DCACHE_SET_ASSOC, ICACHE_INDEX_WIDTH, ICACHE_SET_ASSOC;
        logic [31:0] DCACHE_LINE_WIDTH, ICACHE_LINE_WIDTH;
        logic [31:0] RASDepth, NrPMPEntries, DataTlbEntries, InstrTlbEntries;
        logic [31:0] BHTEntries, BTBEntries;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/cfg_desc_word_sel.sv
// Combinational map from descriptor index to 32-bit word; all words are
// elaboration-time constants. CFG_DESC_CHECKSUM_EN adds the XOR word at index 8.
module cfg_desc_word_sel
    import config_pkg::*, cfg_desc_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic [IDX_W-1:0] i_index,
    output logic [31:0]      o_word
);

    localparam logic [31:0] W0 = {DESC_MAGIC, 8'h00, 8'(NWORDS)};
    localparam logic [31:0] W1 = {sat8(CVA6Cfg.GPLEN), sat8(CVA6Cfg.PLEN),
                                  sat8(CVA6Cfg.VLEN), sat8(CVA6Cfg.XLEN)};
    localparam logic [31:0] W2 = {10'd0,
        CVA6Cfg.FpPresent, CVA6Cfg.DebugEn, CVA6Cfg.MmuPresent, CVA6Cfg.RVU,
        CVA6Cfg.RVS, CVA6Cfg.RVZihpm, CVA6Cfg.RVZicntr, CVA6Cfg.RVZiCond,
        CVA6Cfg.CvxifEn, CVA6Cfg.XFVec, CVA6Cfg.RVZCMP, CVA6Cfg.RVZCB,
        CVA6Cfg.RVH, CVA6Cfg.RVC, CVA6Cfg.RVV, CVA6Cfg.RVB,
        CVA6Cfg.RVA, CVA6Cfg.XF8, CVA6Cfg.XF16ALT, CVA6Cfg.XF16,
        CVA6Cfg.RVD, CVA6Cfg.RVF};
    localparam logic [31:0] W3 = {sat8(CVA6Cfg.FLen), sat8(CVA6Cfg.NR_SB_ENTRIES),
                                  sat4(CVA6Cfg.NrRgprPorts), sat4(CVA6Cfg.NrWbPorts),
                                  sat4(CVA6Cfg.NrIssuePorts), sat4(CVA6Cfg.NrCommitPorts)};
    localparam logic [31:0] W4 = {sat8(CVA6Cfg.DCACHE_INDEX_WIDTH), sat8(CVA6Cfg.DCACHE_SET_ASSOC),
                                  sat8(CVA6Cfg.ICACHE_INDEX_WIDTH), sat8(CVA6Cfg.ICACHE_SET_ASSOC)};
    localparam logic [31:0] W5 = {sat16(CVA6Cfg.DCACHE_LINE_WIDTH), sat16(CVA6Cfg.ICACHE_LINE_WIDTH)};
    localparam logic [31:0] W6 = {sat8(CVA6Cfg.RASDepth), sat8(CVA6Cfg.NrPMPEntries),
                                  sat8(CVA6Cfg.DataTlbEntries), sat8(CVA6Cfg.InstrTlbEntries)};
    localparam logic [31:0] W7 = {sat16(CVA6Cfg.BHTEntries), sat16(CVA6Cfg.BTBEntries)};
`ifdef CFG_DESC_CHECKSUM_EN
    localparam logic [31:0] W8 = W0 ^ W1 ^ W2 ^ W3 ^ W4 ^ W5 ^ W6 ^ W7;
`endif

    // Index-to-word multiplexer; unused indices read as zero.
    always_comb begin
        o_word = 32'd0;
        case (i_index)
            4'd0:    o_word = W0;
            4'd1:    o_word = W1;
            4'd2:    o_word = W2;
            4'd3:    o_word = W3;
            4'd4:    o_word = W4;
            4'd5:    o_word = W5;
            4'd6:    o_word = W6;
            4'd7:    o_word = W7;
`ifdef CFG_DESC_CHECKSUM_EN
            4'd8:    o_word = W8;
`endif
            default: o_word = 32'd0;
        endcase
    end

endmodule

// File: rtl/cfg_desc_streamer.sv
// Streams the core-configuration descriptor as a valid/ready word sequence.
// Optional feature macro: CFG_DESC_CHECKSUM_EN (9-word descriptor with checksum).
module cfg_desc_streamer
    import config_pkg::*, cfg_desc_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        last_o,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 32'd1);

    state_e           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_data;
    logic             r_last;
    logic [IDX_W-1:0] w_sel_idx;
    logic [31:0]      w_word;

    // Look up the word that will be presented after the next load.
    assign w_sel_idx = (r_state == SEND) ? (r_idx + 4'd1) : 4'd0;

    cfg_desc_word_sel #(
        .CVA6Cfg (CVA6Cfg)
    ) u_word_sel (
        .i_index (w_sel_idx),
        .o_word  (w_word)
    );

    // Transfer FSM with registered word/last outputs; abort outranks acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_idx   <= 4'd0;
            r_data  <= 32'd0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= SEND;
                        r_idx   <= 4'd0;
                        r_data  <= w_word;
                        r_last  <= 1'b0;
                    end
                end
                SEND: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                        r_idx   <= 4'd0;
                        r_data  <= 32'd0;
                        r_last  <= 1'b0;
                    end else if (ready_i) begin
                        if (r_last) begin
                            r_state <= DONE;
                            r_idx   <= 4'd0;
                            r_data  <= 32'd0;
                            r_last  <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_data  <= w_word;
                            r_last  <= ((r_idx + 4'd1) == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= 4'd0;
                    r_data  <= 32'd0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o = (r_state == SEND);
    assign busy_o  = (r_state != IDLE);
    assign done_o  = (r_state == DONE);
    assign data_o  = r_data;
    assign last_o  = r_last;

endmodule

// File: tb/tb_cfg_desc_streamer.sv
// Self-checking bench for cfg_desc_streamer: directed scenarios plus randomized
// traffic against a transaction-level model. Honors CFG_DESC_CHECKSUM_EN.
module tb_cfg_desc_streamer;
    import config_pkg::*;

`ifdef CFG_DESC_CHECKSUM_EN
    localparam int NW = 9;
`else
    localparam int NW = 8;
`endif
    localparam logic [31:0] W0_LIT = 32'hC7A6_0000 | 32'(NW);

    function automatic cva6_cfg_t mk_cfg();
        cva6_cfg_t c;
        c = '0;
        c.XLEN = 32'd64; c.VLEN = 32'd64; c.PLEN = 32'd56; c.GPLEN = 32'd41;
        c.RVF = 1'b1; c.RVD = 1'b1; c.RVA = 1'b1; c.RVB = 1'b1; c.RVC = 1'b1;
        c.RVZCB = 1'b1; c.RVZiCond = 1'b1; c.RVZicntr = 1'b1; c.RVZihpm = 1'b1;
        c.RVS = 1'b1; c.RVU = 1'b1; c.MmuPresent = 1'b1; c.DebugEn = 1'b1; c.FpPresent = 1'b1;
        c.FLen = 32'd64; c.NR_SB_ENTRIES = 32'd8; c.NrRgprPorts = 32'd2;
        c.NrWbPorts = 32'd20; c.NrIssuePorts = 32'd1; c.NrCommitPorts = 32'd2;
        c.DCACHE_INDEX_WIDTH = 32'd12; c.DCACHE_SET_ASSOC = 32'd8;
        c.ICACHE_INDEX_WIDTH = 32'd12; c.ICACHE_SET_ASSOC = 32'd4;
        c.DCACHE_LINE_WIDTH = 32'd128; c.ICACHE_LINE_WIDTH = 32'd128;
        c.RASDepth = 32'd2; c.NrPMPEntries = 32'd300;
        c.DataTlbEntries = 32'd16; c.InstrTlbEntries = 32'd16;
        c.BHTEntries = 32'd128; c.BTBEntries = 32'd70000;
        return c;
    endfunction

    localparam cva6_cfg_t TB_CFG = mk_cfg();

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [31:0] data_o;
    logic        valid_o, last_o, busy_o, done_o;

    always #5 clk_i = ~clk_i;

    cfg_desc_streamer #(.CVA6Cfg(TB_CFG)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .abort_i (abort_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .ready_i (ready_i),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_w [0:8];
    int          m_phase = 0;   // 0 idle, 1 streaming, 2 completion cycle
    int          m_idx = 0;
    bit          cmp_en = 1'b0;
    logic [31:0] cap [0:8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int unsigned lim(input int unsigned v, input int unsigned m);
        return (v > m) ? m : v;
    endfunction

    // Expected descriptor built from the field rules with plain arithmetic.
    initial begin
        bit          fl [22];
        int unsigned acc;
        fl = '{TB_CFG.RVF, TB_CFG.RVD, TB_CFG.XF16, TB_CFG.XF16ALT, TB_CFG.XF8, TB_CFG.RVA,
               TB_CFG.RVB, TB_CFG.RVV, TB_CFG.RVC, TB_CFG.RVH, TB_CFG.RVZCB, TB_CFG.RVZCMP,
               TB_CFG.XFVec, TB_CFG.CvxifEn, TB_CFG.RVZiCond, TB_CFG.RVZicntr, TB_CFG.RVZihpm,
               TB_CFG.RVS, TB_CFG.RVU, TB_CFG.MmuPresent, TB_CFG.DebugEn, TB_CFG.FpPresent};
        exp_w[0] = 32'hC7A6_0000 + 32'(NW);
        exp_w[1] = (lim(TB_CFG.GPLEN, 255) << 24) + (lim(TB_CFG.PLEN, 255) << 16)
                 + (lim(TB_CFG.VLEN, 255) << 8) + lim(TB_CFG.XLEN, 255);
        acc = 0;
        for (int i = 0; i < 22; i++) if (fl[i]) acc = acc + (32'd1 << i);
        exp_w[2] = acc;
        exp_w[3] = (lim(TB_CFG.FLen, 255) << 24) + (lim(TB_CFG.NR_SB_ENTRIES, 255) << 16)
                 + (lim(TB_CFG.NrRgprPorts, 15) << 12) + (lim(TB_CFG.NrWbPorts, 15) << 8)
                 + (lim(TB_CFG.NrIssuePorts, 15) << 4) + lim(TB_CFG.NrCommitPorts, 15);
        exp_w[4] = (lim(TB_CFG.DCACHE_INDEX_WIDTH, 255) << 24) + (lim(TB_CFG.DCACHE_SET_ASSOC, 255) << 16)
                 + (lim(TB_CFG.ICACHE_INDEX_WIDTH, 255) << 8) + lim(TB_CFG.ICACHE_SET_ASSOC, 255);
        exp_w[5] = (lim(TB_CFG.DCACHE_LINE_WIDTH, 65535) << 16) + lim(TB_CFG.ICACHE_LINE_WIDTH, 65535);
        exp_w[6] = (lim(TB_CFG.RASDepth, 255) << 24) + (lim(TB_CFG.NrPMPEntries, 255) << 16)
                 + (lim(TB_CFG.DataTlbEntries, 255) << 8) + lim(TB_CFG.InstrTlbEntries, 255);
        exp_w[7] = (lim(TB_CFG.BHTEntries, 65535) << 16) + lim(TB_CFG.BTBEntries, 65535);
        exp_w[8] = 32'd0;
        if (NW == 9) for (int i = 0; i < 8; i++) exp_w[8] = exp_w[8] ^ exp_w[i];
    end

    // Transaction-level reference: advance on each edge from the sampled inputs.
    always @(posedge clk_i) begin
        if (rst_i) begin
            m_phase <= 0; m_idx <= 0;
        end else if (m_phase == 0) begin
            if (start_i) begin m_phase <= 1; m_idx <= 0; end
        end else if (m_phase == 1) begin
            if (abort_i) m_phase <= 0;
            else if (ready_i) begin
                if (m_idx == NW - 1) m_phase <= 2;
                else m_idx <= m_idx + 1;
            end
        end else begin
            m_phase <= 0;
        end
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk_i) begin
        if (cmp_en) begin
            chk("valid", 32'(valid_o), 32'(m_phase == 1));
            chk("busy",  32'(busy_o),  32'(m_phase != 0));
            chk("done",  32'(done_o),  32'(m_phase == 2));
            if (m_phase == 1) begin
                chk("data", data_o, exp_w[m_idx]);
                chk("last", 32'(last_o), 32'(m_idx == NW - 1));
            end
        end
    end

    task automatic drain();
        int c;
        ready_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        c = 0;
        while (busy_o && c < 40) begin @(negedge clk_i); c++; end
        chk("drain_timeout", 32'(busy_o), 32'd0);
        @(negedge clk_i);
    endtask

    initial begin
        int nw, nlast, lastpos, hs_cyc, done_cyc, ndone;
        logic [31:0] held, xr;
        logic        held_last;

        repeat (3) @(negedge clk_i);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data",  data_o, 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        rst_i = 1'b0; cmp_en = 1'b1;

        // Full descriptor at full throughput with literal expectations.
        start_i = 1'b1; ready_i = 1'b1;
        nw = 0; nlast = 0; lastpos = -1; hs_cyc = -1; done_cyc = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (done_o && done_cyc < 0) done_cyc = c;
            if (valid_o) begin
                if (nw < 9) cap[nw] = data_o;
                if (last_o) begin nlast++; lastpos = nw; hs_cyc = c; end
                nw++;
            end
        end
        chk("a_w0", cap[0], W0_LIT);
        chk("a_w1", cap[1], 32'h2938_4040);
        chk("a_w6_pmp_sat", 32'(cap[6][23:16]), 32'h0000_00FF);
        chk("a_w7_btb_sat", 32'(cap[7][15:0]), 32'h0000_FFFF);
        chk("a_nwords", 32'(nw), 32'(NW));
        chk("a_nlast", 32'(nlast), 32'd1);
        chk("a_lastpos", 32'(lastpos), 32'(NW - 1));
        chk("a_done_cyc", 32'(done_cyc), 32'(hs_cyc + 1));
        if (NW == 9) begin
            xr = 32'd0;
            for (int i = 0; i < 8; i++) xr = xr ^ cap[i];
            chk("a_checksum", cap[8], xr);
        end

        // Backpressure: stall three cycles on W2.
        start_i = 1'b1; ready_i = 1'b1;
        repeat (3) begin @(negedge clk_i); start_i = 1'b0; end
        held = data_o; held_last = last_o; ready_i = 1'b0;
        chk("b_w2", held, exp_w[2]);
        repeat (3) begin
            @(negedge clk_i);
            chk("b_hold_data", data_o, held);
            chk("b_hold_last", 32'(last_o), 32'(held_last));
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("b_w3_next", data_o, exp_w[3]);
        drain();

        // Abort together with acceptance on W4, then restart.
        start_i = 1'b1; ready_i = 1'b1;
        repeat (5) begin @(negedge clk_i); start_i = 1'b0; end
        chk("c_w4", data_o, exp_w[4]);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("c_abort_valid", 32'(valid_o), 32'd0);
        ndone = 0;
        repeat (4) begin if (done_o) ndone++; @(negedge clk_i); end
        chk("c_no_done", 32'(ndone), 32'd0);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("c_restart_w0", data_o, W0_LIT);
        drain();

        // Redundant start pulses while streaming.
        start_i = 1'b1; ready_i = 1'b1; nw = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            start_i = (c == 2 || c == 4) ? 1'b1 : 1'b0;
            if (valid_o) nw++;
            if (done_o) break;
        end
        start_i = 1'b0;
        chk("d_count", 32'(nw), 32'(NW));
        drain();

        // Reset mid-stream.
        start_i = 1'b1; ready_i = 1'b1;
        repeat (3) begin @(negedge clk_i); start_i = 1'b0; end
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("e_rst_valid", 32'(valid_o), 32'd0);
        chk("e_rst_data",  data_o, 32'd0);
        chk("e_rst_last",  32'(last_o), 32'd0);
        chk("e_rst_busy",  32'(busy_o), 32'd0);
        chk("e_rst_done",  32'(done_o), 32'd0);
        rst_i = 1'b0;

        // Randomized traffic checked by the per-cycle compare.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            rst_i   = ($urandom_range(0, 199) == 0);
            start_i = ($urandom_range(0, 3) == 0);
            abort_i = ($urandom_range(0, 29) == 0);
            ready_i = ($urandom_range(0, 9) < 7);
        end
        rst_i = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cfg_desc_streamer.md
CFG_DESC_STREAMER -- requirements
Module: cfg_desc_streamer

Interface
REQ-001 The block SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty; this is the elaborated core configuration to be serialized.
REQ-002 The block SHALL have port clk_i, input, 1 bit; the single clock.
REQ-003 The block SHALL have port rst_i, input, 1 bit; reset, synchronous and active-high.
REQ-004 The block SHALL have port start_i, input, 1 bit; a request to begin one descriptor transfer.
REQ-005 The block SHALL have port abort_i, input, 1 bit; cancels a transfer in progress.
REQ-006 The block SHALL have port data_o, output, 32 bits; the current descriptor word.
REQ-007 The block SHALL have port valid_o, output, 1 bit; data_o is valid.
REQ-008 The block SHALL have port last_o, output, 1 bit; data_o is the final word.
REQ-009 The block SHALL have port ready_i, input, 1 bit; the consumer accepts data_o.
REQ-010 The block SHALL have port busy_o, output, 1 bit; a transfer is in progress.
REQ-011 The block SHALL have port done_o, output, 1 bit; a one-cycle pulse on completion.

Function
REQ-012 The FSM SHALL have three states: IDLE, SEND and DONE.
- IDLE to SEND on start_i.
- SEND to DONE when the last word is accepted.
- DONE to IDLE unconditionally after one cycle.
REQ-013 start_i sampled in IDLE at cycle t SHALL produce valid_o=1 with word 0 at cycle t+1.
- start_i SHALL be ignored in SEND and DONE.
REQ-014 A word SHALL be accepted when valid_o and ready_i are both high.
- While valid_o=1 and ready_i=0, data_o and last_o SHALL be held stable.
- Between accepted words there SHALL be zero bubble cycles.
REQ-015 The word index counter SHALL increment only on acceptance and SHALL reset to 0 on entry to SEND.
REQ-016 Descriptor word layout, with fields listed MSB to LSB:
- W0 = 0xC7A6 in [31:16], 0x00 in [15:8], NWORDS in [7:0].
- W1 = {GPLEN, PLEN, VLEN, XLEN}, 8 bits each.
- W2 = ISA flag bits [0..21] = RVF, RVD, XF16, XF16ALT, XF8, RVA, RVB, RVV, RVC, RVH, RVZCB, RVZCMP, XFVec, CvxifEn, RVZiCond, RVZicntr, RVZihpm, RVS, RVU, MmuPresent, DebugEn, FpPresent; bits [31:22] = 0.
- W3 = {FLen[8], NR_SB_ENTRIES[8], NrRgprPorts[4], NrWbPorts[4], NrIssuePorts[4], NrCommitPorts[4]}.
- W4 = {DCACHE_INDEX_WIDTH, DCACHE_SET_ASSOC, ICACHE_INDEX_WIDTH, ICACHE_SET_ASSOC}, 8 bits each.
- W5 = {DCACHE_LINE_WIDTH[16], ICACHE_LINE_WIDTH[16]}.
- W6 = {RASDepth, NrPMPEntries, DataTlbEntries, InstrTlbEntries}, 8 bits each.
- W7 = {BHTEntries[16], BTBEntries[16]}.
REQ-017 Any value wider than its field SHALL saturate to all-ones, not truncate.
REQ-018 last_o SHALL be 1 only while the word index equals NWORDS-1.
REQ-019 done_o SHALL pulse high for exactly the DONE cycle, and busy_o SHALL be 1 in SEND and DONE.
REQ-020 abort_i in SEND SHALL move the FSM to IDLE at the next edge.
- valid_o=0 from the next cycle.
- No done_o pulse.
- abort_i SHALL take priority over a simultaneous acceptance.
- abort_i SHALL be ignored in IDLE and DONE.
REQ-021 data_o and last_o SHALL be registered outputs; valid_o SHALL be driven directly from FSM state.

Reset
REQ-022 rst_i SHALL force the FSM to IDLE and set the index to 0, valid_o=0, last_o=0, data_o=0, busy_o=0 and done_o=0, including mid-transfer.
REQ-023 rst_i SHALL take priority over start_i and abort_i in the same cycle.

Configuration
REQ-024 With macro CFG_DESC_CHECKSUM_EN defined, a 9th word W8 SHALL be appended, NWORDS SHALL be 9, and W8 SHALL be the XOR of W0 through W7.
REQ-025 Without CFG_DESC_CHECKSUM_EN, NWORDS SHALL be 8 and W7 SHALL carry last_o.

Structure
REQ-026 Package cfg_desc_pkg SHALL hold:
- the magic constant 0xC7A6;
- the NWORDS base value 8;
- the field offset/width constants;
- the state enum typedef.
REQ-027 One combinational sub-module, cfg_desc_word_sel, SHALL map (CVA6Cfg, index) to a 32-bit word, including saturation; the checksum SHALL be a constant computed at elaboration.

Verification
REQ-028 Run with a cv64a6 config (XLEN=64, VLEN=64, PLEN=56, GPLEN=41), start_i pulsed, and ready_i=1.
- W0 SHALL be 0xC7A60008, and W1 SHALL be 0x29384040.
- last_o SHALL be high on W7 only.
- done_o SHALL pulse one cycle after the W7 handshake.
REQ-029 Hold ready_i=0 for 3 cycles while W2 is presented: data_o and last_o SHALL stay stable for all 3 cycles, and W3 SHALL follow one cycle after ready_i rises.
REQ-030 Assert abort_i together with ready_i on W4: valid_o SHALL be 0 next cycle, no done_o pulse SHALL occur, and a new start_i SHALL restart at W0.
REQ-031 Pulse start_i again during SEND: there SHALL be no effect, and the word sequence and count SHALL be unchanged.
REQ-032 Set BTBEntries=70000 and NrPMPEntries=300: W7[15:0] SHALL be 0xFFFF and W6[23:16] SHALL be 0xFF.
REQ-033 With CFG_DESC_CHECKSUM_EN defined, W0[7:0] SHALL be 9, W8 SHALL equal the XOR of W0 through W7, and last_o SHALL be high on W8; assert rst_i mid-stream and all outputs SHALL be 0 next cycle.
